// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display controller.
// All glyphs are active-low: bit 0 = segment a, bit 6 = segment g.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0 ('0') sits in the lowest bits; index 15 ('F') in the highest.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {IDLE, CONV} state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit value to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPHS[nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: hex or double-dabble decimal display
// with leading-zero blanking, overflow dashes and blinking.
module seg_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segs
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PAD_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t              state, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [BCD_W-1:0]    bcd, bcd_adj, bcd_next, digits, hex_digits;
  logic                over, over_bit, last_step, hex_over, overflow_r;
  logic [CNT_W-1:0]    conv_cnt;
  logic [PAD_W-1:0]    data_pad;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_on;
  logic [7*NUM_DIGITS-1:0] glyphs, segs_next;
  logic [NUM_DIGITS-1:0]   shown;
  logic                    seen;

  // Nibbles past the top of wr_data read as zero.
  assign data_pad   = PAD_W'(wr_data);
  assign hex_digits = data_pad[BCD_W-1:0];

  generate
    if (PAD_W > BCD_W) begin : g_hex_ovf
      assign hex_over = |data_pad[PAD_W-1:BCD_W];
    end else begin : g_no_hex_ovf
      assign hex_over = 1'b0;
    end
  endgenerate

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign {bcd_next, shift_next} = {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
  assign over_bit  = bcd_adj[BCD_W-1];
  assign last_step = (conv_cnt == CNT_W'(DATA_W - 1));
  assign busy      = (state == CONV);
  assign overflow  = overflow_r;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wr_en && mode) state_next = CONV;
      CONV:    if (last_step)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bcd        <= '0;
      over       <= 1'b0;
      conv_cnt   <= '0;
      digits     <= '0;
      overflow_r <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (wr_en && mode) begin
          shift_reg <= wr_data;
          bcd       <= '0;
          over      <= 1'b0;
          conv_cnt  <= '0;
        end else if (wr_en) begin
          digits     <= hex_digits;
          overflow_r <= hex_over;
        end
      end else begin
        // Writes arriving here are dropped; the conversion runs undisturbed.
        shift_reg <= shift_next;
        bcd       <= bcd_next;
        over      <= over | over_bit;
        conv_cnt  <= conv_cnt + CNT_W'(1);
        if (last_step) begin
          digits     <= bcd_next;
          overflow_r <= over | over_bit;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_to_seg7 u_dec (
      .nibble (digits[4*g +: 4]),
      .seg    (glyphs[7*g +: 7])
    );
  end

  // Priority: blink-off blanking, then overflow dashes, then leading-zero blanking.
  always_comb begin
    seen      = 1'b0;
    shown     = '0;
    segs_next = glyphs;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (digits[4*i +: 4] != 4'd0);
      shown[i] = seen || (i == 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blink_en && !blink_on)       segs_next[7*i +: 7] = SEG_BLANK;
      else if (overflow_r)             segs_next[7*i +: 7] = SEG_DASH;
      else if (blank_lz && !shown[i])  segs_next[7*i +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) segs <= {NUM_DIGITS{SEG_GLYPHS[0]}};
    else       segs <= segs_next;
  end

endmodule
